// File: rtl/io_handshake_pkg.sv
// Shared types and helpers for the I/O handshake responder.
// Latency: n/a (types and a pure combinational decode function only).
// Backpressure: n/a.
//
// Contents:
//   state_e     - responder FSM states
//   req_e       - request kinds decoded from the core's is_input/is_output flags
//   decode_req  - flag pair -> request kind
package io_handshake_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      ACK          = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REQ_NONE  = 2'd0,
      REQ_OUT   = 2'd1,
      REQ_IN    = 2'd2,
      REQ_PAUSE = 2'd3
   } req_e;

   // Both flags high is how the core encodes a PAUSE instruction.
   function automatic req_e decode_req(input logic is_input, input logic is_output);
      req_e r;
      case ({is_input, is_output})
         2'b01:   r = REQ_OUT;
         2'b10:   r = REQ_IN;
         2'b11:   r = REQ_PAUSE;
         default: r = REQ_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/io_handshake_responder_button_debouncer.sv
// Button conditioning: 2-FF synchronizer, stability-counter debounce, press pulse.
// Latency: raw edge -> accepted level / press pulse after 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press_o is a one-cycle pulse that is lost if not consumed.
//
// Ports:
//   clock, reset  - system clock, asynchronous active-low reset (accepted = released)
//   raw_i         - raw asynchronous active-high button
//   level_o       - debounced (accepted) button level
//   press_o       - one-cycle pulse on an accepted 0->1 transition
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= raw_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter only advances while the synchronized level disagrees with the
   // accepted one; any cycle of agreement (a bounce back) restarts it from zero.
   // The flip happens on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync_q;
            press_d = sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/io_handshake_responder.sv
// Peripheral side of the core's I/O handshake: decodes OUT/IN/PAUSE requests and acknowledges on a fresh button press.
// Latency: press pulse -> ACK next cycle; raw button edge -> pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: core stalls until confirmation/continue_button; a held button cannot acknowledge twice.
//
// Ports:
//   clock, reset                 - system clock, asynchronous active-low reset
//   is_input, is_output          - core request flags (both high = PAUSE)
//   data_out                     - value latched into display_value on an OUT request
//   switches                     - board switches, captured zero-extended into data_in on IN acknowledge
//   raw_confirm_button           - raw button acknowledging OUT/IN
//   raw_continue_button          - raw button acknowledging PAUSE
//   confirmation/continue_button - one-cycle acknowledge pulses (mutually exclusive)
//   data_in, display_value       - captured input word / latched display word
//   waiting                      - request pending, waiting for the button
module io_handshake_responder
   import io_handshake_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int SWITCH_WIDTH    = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    is_input,
   input  logic                    is_output,
   input  logic [DATA_WIDTH-1:0]   data_out,
   input  logic [SWITCH_WIDTH-1:0] switches,
   input  logic                    raw_confirm_button,
   input  logic                    raw_continue_button,
   output logic                    confirmation,
   output logic                    continue_button,
   output logic [DATA_WIDTH-1:0]   data_in,
   output logic [DATA_WIDTH-1:0]   display_value,
   output logic                    waiting
);

   state_e                  state_q, state_d;
   req_e                    req_q, req_d;
   req_e                    req_now;
   logic [DATA_WIDTH-1:0]   display_q, display_d;
   logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;

   logic                    conf_level, conf_press;
   logic                    cont_level, cont_press;
   logic                    sel_press;
   logic                    sel_level;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_confirm_db (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_confirm_button),
      .level_o (conf_level),
      .press_o (conf_press)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_continue_db (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_continue_button),
      .level_o (cont_level),
      .press_o (cont_press)
   );

   assign req_now = decode_req(is_input, is_output);

   // PAUSE is answered by the continue button; OUT and IN by the confirm button.
   // The other button is simply not looked at.
   assign sel_press = (req_q == REQ_PAUSE) ? cont_press : conf_press;
   assign sel_level = (req_q == REQ_PAUSE) ? cont_level : conf_level;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         req_q     <= REQ_NONE;
         display_q <= '0;
         data_in_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         display_q <= display_d;
         data_in_q <= data_in_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      display_d       = display_q;
      data_in_d       = data_in_q;
      confirmation    = 1'b0;
      continue_button = 1'b0;
      waiting         = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_now != REQ_NONE) begin
               state_d = WAIT_PRESS;
               req_d   = req_now;
               if (req_now == REQ_OUT) begin
                  display_d = data_out;
               end
            end
         end

         WAIT_PRESS: begin
            waiting = 1'b1;
            if (req_now == REQ_NONE) begin
               state_d = IDLE;
            end else if (req_now != req_q) begin
               // Restart with the new kind; a press pulse landing in this same
               // cycle belongs to the old request and is dropped.
               req_d = req_now;
               if (req_now == REQ_OUT) begin
                  display_d = data_out;
               end
            end else if (sel_press) begin
               state_d = ACK;
               // Captured on entry so data_in is already valid while the
               // confirmation pulse is high.
               if (req_q == REQ_IN) begin
                  data_in_d = DATA_WIDTH'(switches);
               end
            end
         end

         ACK: begin
            if (req_q == REQ_PAUSE) begin
               continue_button = 1'b1;
            end else begin
               confirmation = 1'b1;
            end
            state_d = WAIT_RELEASE;
         end

         WAIT_RELEASE: begin
            // Holding the button must not acknowledge the next I/O instruction.
            if (!sel_level) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_in       = data_in_q;
   assign display_value = display_q;

endmodule

// File: tb/tb_io_handshake_responder.sv
// Self-checking bench for io_handshake_responder with DEBOUNCE_CYCLES = 4.
// Expected acknowledge pulses (kind, cycle, captured word) are queued when a
// press is driven and popped by a negedge monitor when a pulse appears.
module tb_io_handshake_responder;

   localparam int DW = 32;
   localparam int SW = 16;
   localparam int DB = 4;
   // raw edge -> pulse: 2 sync + DB stable + 1 FSM
   localparam int ACK_LAT = 2 + DB + 1;

   logic            clock = 1'b0;
   logic            reset;
   logic            is_input;
   logic            is_output;
   logic [DW-1:0]   data_out;
   logic [SW-1:0]   switches;
   logic            raw_confirm_button;
   logic            raw_continue_button;
   logic            confirmation;
   logic            continue_button;
   logic [DW-1:0]   data_in;
   logic [DW-1:0]   display_value;
   logic            waiting;

   always #5 clock = ~clock;

   io_handshake_responder #(
      .DATA_WIDTH      (DW),
      .SWITCH_WIDTH    (SW),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .is_input            (is_input),
      .is_output           (is_output),
      .data_out            (data_out),
      .switches            (switches),
      .raw_confirm_button  (raw_confirm_button),
      .raw_continue_button (raw_continue_button),
      .confirmation        (confirmation),
      .continue_button     (continue_button),
      .data_in             (data_in),
      .display_value       (display_value),
      .waiting             (waiting)
   );

   // kind: 0 = confirmation, 1 = continue_button
   // sel : 0 = no data check, 1 = display_value, 2 = data_in
   typedef struct {
      bit          kind;
      int unsigned cyc;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   logic        prev_pulse = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Queue the pulse expected ACK_LAT cycles after the raw edge driven now.
   task automatic expect_pulse(input bit kind, input int sel, input logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.cyc  = cyc + ACK_LAT;
      e.sel  = sel;
      e.val  = val;
      sb.push_back(e);
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (confirmation || continue_button) begin
         chk("pulse_exclusive", {31'b0, confirmation & continue_button}, 32'd0);
         chk("pulse_width", {31'b0, prev_pulse}, 32'd0);
         chk("pulse_was_expected", {31'b0, (sb.size() > 0)}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_kind", {31'b0, continue_button}, {31'b0, e.kind});
            if (e.sel == 1) chk("display_at_ack", display_value, e.val);
            else if (e.sel == 2) chk("data_in_at_ack", data_in, e.val);
         end
      end
      prev_pulse = confirmation | continue_button;
   end

   initial begin
      reset               = 1'b0;
      is_input            = 1'b0;
      is_output           = 1'b0;
      data_out            = '0;
      switches            = '0;
      raw_confirm_button  = 1'b0;
      raw_continue_button = 1'b0;

      // Reset state
      step(3);
      chk("rst_confirmation", {31'b0, confirmation}, 32'd0);
      chk("rst_continue", {31'b0, continue_button}, 32'd0);
      chk("rst_data_in", data_in, 32'd0);
      chk("rst_display", display_value, 32'd0);
      chk("rst_waiting", {31'b0, waiting}, 32'd0);
      reset = 1'b1;
      step(2);

      // OUTPUT
      is_output = 1'b1;
      data_out  = 32'h0000_00A5;
      step(1);
      chk("out_display_loaded", display_value, 32'h0000_00A5);
      chk("out_waiting", {31'b0, waiting}, 32'd1);
      expect_pulse(1'b0, 1, 32'h0000_00A5);
      raw_confirm_button = 1'b1;
      step(8);
      is_output = 1'b0;          // core re-issues while the button is still held
      step(1);
      is_output = 1'b1;
      step(1);
      chk("out_hold_not_waiting", {31'b0, waiting}, 32'd0);
      is_output          = 1'b0;
      raw_confirm_button = 1'b0;
      step(10);
      chk("out_idle_after_release", {31'b0, waiting}, 32'd0);

      // INPUT
      is_input = 1'b1;
      switches = 16'hBEEF;
      step(2);
      chk("in_waiting", {31'b0, waiting}, 32'd1);
      expect_pulse(1'b0, 2, 32'h0000_BEEF);
      raw_confirm_button = 1'b1;
      step(8);
      switches = 16'h1234;
      step(2);
      raw_confirm_button = 1'b0;
      is_input           = 1'b0;
      step(10);
      chk("in_data_in_held", data_in, 32'h0000_BEEF);
      chk("in_display_untouched", display_value, 32'h0000_00A5);

      // PAUSE: confirm is ignored, continue acknowledges
      is_input  = 1'b1;
      is_output = 1'b1;
      step(2);
      raw_confirm_button = 1'b1;
      step(10);
      chk("pause_still_waiting", {31'b0, waiting}, 32'd1);
      raw_confirm_button = 1'b0;
      step(8);
      expect_pulse(1'b1, 0, 32'd0);
      raw_continue_button = 1'b1;
      step(10);
      chk("pause_released_wait", {31'b0, waiting}, 32'd0);
      is_input            = 1'b0;
      is_output           = 1'b0;
      raw_continue_button = 1'b0;
      step(10);

      // Bounce: 2-cycle toggles never reach 4 stable cycles
      is_output = 1'b1;
      data_out  = 32'h0000_003C;
      step(2);
      for (int i = 0; i < 5; i++) begin
         raw_confirm_button = 1'b1;
         step(2);
         raw_confirm_button = 1'b0;
         step(2);
      end
      expect_pulse(1'b0, 1, 32'h0000_003C);
      raw_confirm_button = 1'b1;
      step(10);
      is_output          = 1'b0;
      raw_confirm_button = 1'b0;
      step(10);
      chk("bounce_display", display_value, 32'h0000_003C);

      // Abort before any press
      is_output = 1'b1;
      data_out  = 32'h0000_0077;
      step(2);
      chk("abort_waiting", {31'b0, waiting}, 32'd1);
      is_output = 1'b0;
      step(1);
      chk("abort_idle", {31'b0, waiting}, 32'd0);
      raw_confirm_button = 1'b1;
      step(10);
      chk("abort_no_wait", {31'b0, waiting}, 32'd0);
      chk("abort_display", display_value, 32'h0000_0077);
      raw_confirm_button = 1'b0;
      step(10);

      // Reset during WAIT_RELEASE
      is_input = 1'b1;
      switches = 16'h00FF;
      step(2);
      expect_pulse(1'b0, 2, 32'h0000_00FF);
      raw_confirm_button = 1'b1;
      step(9);
      chk("mid_wait_release", {31'b0, waiting}, 32'd0);
      chk("mid_data_in", data_in, 32'h0000_00FF);
      reset              = 1'b0;
      raw_confirm_button = 1'b0;
      #1;
      chk("mrst_confirmation", {31'b0, confirmation}, 32'd0);
      chk("mrst_continue", {31'b0, continue_button}, 32'd0);
      chk("mrst_data_in", data_in, 32'd0);
      chk("mrst_display", display_value, 32'd0);
      chk("mrst_waiting", {31'b0, waiting}, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      step(10);
      chk("post_rst_waiting", {31'b0, waiting}, 32'd1);
      chk("post_rst_data_in", data_in, 32'd0);
      switches = 16'hCAFE;
      expect_pulse(1'b0, 2, 32'h0000_CAFE);
      raw_confirm_button = 1'b1;
      step(10);
      raw_confirm_button = 1'b0;
      is_input           = 1'b0;
      step(10);
      chk("post_rst_data_in_held", data_in, 32'h0000_CAFE);

      chk("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
